// File: rtl/video_core_avs_csr.sv
// video_core_avs_csr
// Avalon-MM CSR responder for one video pipeline core. Software writes a
// shadow copy of the core configuration; the shadow is copied into the active
// copy (which drives the core) only at start-of-frame or on an explicit
// immediate-commit command, so the core never changes config mid-frame.
//
// Bus handshake: there is no waitrequest. A write or read is accepted in the
// cycle its strobe is high. Read data is returned exactly one cycle later
// together with a one-cycle avs_readdatavalid; readdata is zero whenever
// readdatavalid is low. A read and a write in the same cycle both take
// effect, and the read returns the value held before the write.
//
// Register map (word addresses):
//   0 CTRL   RW  bit0 = shadow bypass
//   1 PARAM  RW  [PARAM_WIDTH-1:0] shadow parameter, unused high bits read 0
//   2 STATUS RO  bit0 = pending, bit1 = active bypass, [31:16] = frame count
//   3 CMD    WO  bit0 = immediate commit, bit1 = clear frame count; reads 0
// Any other address reads 0 and ignores writes.
module video_core_avs_csr #(
    parameter int                     ADDR_WIDTH  = 2,
    parameter int                     PARAM_WIDTH = 32,
    parameter logic                   BYPASS_RST  = 1'b0,
    parameter logic [PARAM_WIDTH-1:0] PARAM_RST   = '0,
    parameter int                     FCNT_WIDTH  = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [ADDR_WIDTH-1:0]  avs_address,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    input  logic                   avs_read,
    output logic [31:0]            avs_readdata,
    output logic                   avs_readdatavalid,
    input  logic                   sof,
    output logic                   cfg_bypass,
    output logic [PARAM_WIDTH-1:0] cfg_param,
    output logic                   cfg_update
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PARAM  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CMD    = ADDR_WIDTH'(3);

    logic                   r_shadow_bypass;
    logic [PARAM_WIDTH-1:0] r_shadow_param;
    logic                   r_active_bypass;
    logic [PARAM_WIDTH-1:0] r_active_param;
    logic                   r_pending;
    logic [FCNT_WIDTH-1:0]  r_fcnt;
    logic [31:0]            r_readdata;
    logic                   r_readdatavalid;
    logic                   r_update;

    logic                   w_wr_ctrl;
    logic                   w_wr_param;
    logic                   w_wr_cmd;
    logic                   w_wr_shadow;
    logic                   w_commit;
    logic                   w_fcnt_clear;
    logic [31:0]            w_status;
    logic [31:0]            w_rd_mux;

    // Write decode, commit and counter-clear conditions
    always_comb begin
        w_wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
        w_wr_param   = avs_write && (avs_address == ADDR_PARAM);
        w_wr_cmd     = avs_write && (avs_address == ADDR_CMD);
        w_wr_shadow  = w_wr_ctrl || w_wr_param;
        // A coincident sof and CMD commit collapse into a single commit.
        w_commit     = (sof && r_pending) || (w_wr_cmd && avs_writedata[0]);
        w_fcnt_clear = w_wr_cmd && avs_writedata[1];
    end

    // Read mux built from pre-write register contents
    always_comb begin
        w_status = {16'(r_fcnt), 14'd0, r_active_bypass, r_pending};
        w_rd_mux = 32'd0;
        case (avs_address)
            ADDR_CTRL:   w_rd_mux = {31'd0, r_shadow_bypass};
            ADDR_PARAM:  w_rd_mux = 32'(r_shadow_param);
            ADDR_STATUS: w_rd_mux = w_status;
            default:     w_rd_mux = 32'd0;
        endcase
    end

    // Shadow registers and the pending flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_shadow_bypass <= BYPASS_RST;
            r_shadow_param  <= PARAM_RST;
            r_pending       <= 1'b0;
        end else begin
            if (w_wr_ctrl)  r_shadow_bypass <= avs_writedata[0];
            if (w_wr_param) r_shadow_param  <= avs_writedata[PARAM_WIDTH-1:0];
            // A same-cycle shadow write keeps pending set across a commit.
            if (w_wr_shadow)   r_pending <= 1'b1;
            else if (w_commit) r_pending <= 1'b0;
        end
    end

    // Active registers take the shadow as it stood before this cycle's write
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_active_bypass <= BYPASS_RST;
            r_active_param  <= PARAM_RST;
            r_update        <= 1'b0;
        end else begin
            if (w_commit) begin
                r_active_bypass <= r_shadow_bypass;
                r_active_param  <= r_shadow_param;
            end
            r_update <= w_commit;
        end
    end

    // Frame counter: wraps naturally; clear beats a same-cycle sof
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_fcnt <= '0;
        end else if (w_fcnt_clear) begin
            r_fcnt <= '0;
        end else if (sof) begin
            r_fcnt <= r_fcnt + FCNT_WIDTH'(1);
        end
    end

    // One-cycle read return; data forced to zero when not valid
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_readdata      <= 32'd0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= avs_read;
            r_readdata      <= avs_read ? w_rd_mux : 32'd0;
        end
    end

    assign avs_readdata      = r_readdata;
    assign avs_readdatavalid = r_readdatavalid;
    assign cfg_bypass        = r_active_bypass;
    assign cfg_param         = r_active_param;
    assign cfg_update        = r_update;

endmodule

// File: tb/tb_video_core_avs_csr.sv
// Directed testbench for video_core_avs_csr. The DUT is built with a 3-bit
// address so that out-of-map addresses (e.g. 5) can be exercised directly.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_video_core_avs_csr;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        sof;
  logic        cfg_bypass;
  logic [31:0] cfg_param;
  logic        cfg_update;

  int errors = 0;
  int checks = 0;

  video_core_avs_csr #(
    .ADDR_WIDTH (3),
    .PARAM_WIDTH(32),
    .FCNT_WIDTH (16)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .avs_address      (avs_address),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_read         (avs_read),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .sof              (sof),
    .cfg_bypass       (cfg_bypass),
    .cfg_param        (cfg_param),
    .cfg_update       (cfg_update)
  );

  // clock / reset block
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic rd_check(input logic [2:0] addr, input logic [31:0] expv, input string tag);
    avs_address = addr;
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    check({tag, "_valid"}, {31'd0, avs_readdatavalid}, 32'd1);
    check(tag, avs_readdata, expv);
  endtask

  task automatic sof_pulse();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  logic [2:0]  t6_addr [4];
  logic [31:0] t6_exp  [4];

  initial begin
    sys_rst       = 1'b1;
    avs_address   = '0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    avs_read      = 1'b0;
    sof           = 1'b0;

    // T1 reset
    tick();
    tick();
    sys_rst = 1'b0;
    check("rst_bypass", {31'd0, cfg_bypass}, 32'd0);
    check("rst_param", cfg_param, 32'd0);
    check("rst_update", {31'd0, cfg_update}, 32'd0);
    check("rst_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
    check("rst_rddata", avs_readdata, 32'd0);
    rd_check(3'd2, 32'h0000_0000, "rst_status");

    // T2 deferred commit
    wr(3'd0, 32'h1);
    check("t2_bypass_held", {31'd0, cfg_bypass}, 32'd0);
    wr(3'd1, 32'h55);
    check("t2_param_held", cfg_param, 32'd0);
    check("t2_no_update", {31'd0, cfg_update}, 32'd0);
    rd_check(3'd2, 32'h0000_0001, "t2_status_pending");
    rd_check(3'd0, 32'h1, "t2_ctrl_rd");
    rd_check(3'd1, 32'h55, "t2_param_rd");
    sof_pulse();
    check("t2_bypass", {31'd0, cfg_bypass}, 32'd1);
    check("t2_param", cfg_param, 32'h55);
    check("t2_update", {31'd0, cfg_update}, 32'd1);
    tick();
    check("t2_update_1cyc", {31'd0, cfg_update}, 32'd0);
    rd_check(3'd2, 32'h0001_0002, "t2_status");

    // T3 write colliding with sof
    wr(3'd1, 32'h11);
    avs_address   = 3'd1;
    avs_writedata = 32'hAA;
    avs_write     = 1'b1;
    sof           = 1'b1;
    tick();
    avs_write     = 1'b0;
    sof           = 1'b0;
    check("t3_param_old", cfg_param, 32'h11);
    check("t3_update", {31'd0, cfg_update}, 32'd1);
    rd_check(3'd2, 32'h0002_0003, "t3_status_pending");
    rd_check(3'd1, 32'hAA, "t3_param_rd");
    sof_pulse();
    check("t3_param_new", cfg_param, 32'hAA);
    rd_check(3'd2, 32'h0003_0002, "t3_status");

    // T4 immediate commit, sof without pending, sof+CMD together
    wr(3'd1, 32'h7);
    wr(3'd3, 32'h1);
    check("t4_param", cfg_param, 32'h7);
    check("t4_update", {31'd0, cfg_update}, 32'd1);
    tick();
    check("t4_update_1cyc", {31'd0, cfg_update}, 32'd0);
    rd_check(3'd2, 32'h0003_0002, "t4_status");
    sof_pulse();
    check("t4_sof_nopend_update", {31'd0, cfg_update}, 32'd0);
    rd_check(3'd2, 32'h0004_0002, "t4_status_fcnt");
    wr(3'd1, 32'h9);
    avs_address   = 3'd3;
    avs_writedata = 32'h1;
    avs_write     = 1'b1;
    sof           = 1'b1;
    tick();
    avs_write     = 1'b0;
    sof           = 1'b0;
    check("t4_both_param", cfg_param, 32'h9);
    check("t4_both_update", {31'd0, cfg_update}, 32'd1);
    tick();
    check("t4_both_single", {31'd0, cfg_update}, 32'd0);
    rd_check(3'd3, 32'h0, "t4_cmd_rd");
    wr(3'd2, 32'hFFFF_FFFF);
    rd_check(3'd2, 32'h0005_0002, "t4_status_ro");
    wr(3'd5, 32'h33);
    rd_check(3'd1, 32'h9, "t4_addr5_noalias");
    rd_check(3'd2, 32'h0005_0002, "t4_addr5_nopend");

    // same-cycle read and write returns pre-write value
    avs_address   = 3'd1;
    avs_writedata = 32'h44;
    avs_write     = 1'b1;
    avs_read      = 1'b1;
    tick();
    avs_write     = 1'b0;
    avs_read      = 1'b0;
    check("rw_prewrite", avs_readdata, 32'h9);
    rd_check(3'd1, 32'h44, "rw_postwrite");

    // T5 frame counter clear and wrap (pending sof also commits 0x44)
    avs_address   = 3'd3;
    avs_writedata = 32'h2;
    avs_write     = 1'b1;
    sof           = 1'b1;
    tick();
    avs_write     = 1'b0;
    sof           = 1'b0;
    check("t5_clear_commit", cfg_param, 32'h44);
    rd_check(3'd2, 32'h0000_0002, "t5_clear");
    sof = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    sof = 1'b0;
    rd_check(3'd2, 32'hFFFF_0002, "t5_max");
    sof_pulse();
    rd_check(3'd2, 32'h0000_0002, "t5_wrap");

    // T6 back-to-back reads
    t6_addr[0] = 3'd0; t6_exp[0] = 32'h1;
    t6_addr[1] = 3'd1; t6_exp[1] = 32'h44;
    t6_addr[2] = 3'd2; t6_exp[2] = 32'h0000_0002;
    t6_addr[3] = 3'd5; t6_exp[3] = 32'h0;
    avs_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      avs_address = t6_addr[i];
      tick();
      check($sformatf("t6_valid%0d", i), {31'd0, avs_readdatavalid}, 32'd1);
      check($sformatf("t6_data%0d", i), avs_readdata, t6_exp[i]);
    end
    avs_read = 1'b0;
    tick();
    check("t6_valid_end", {31'd0, avs_readdatavalid}, 32'd0);
    check("t6_data_end", avs_readdata, 32'd0);

    // reset mid-operation with a read in flight
    avs_address = 3'd1;
    avs_read    = 1'b1;
    sys_rst     = 1'b1;
    tick();
    avs_read    = 1'b0;
    sys_rst     = 1'b0;
    check("mid_rst_valid", {31'd0, avs_readdatavalid}, 32'd0);
    check("mid_rst_data", avs_readdata, 32'd0);
    check("mid_rst_param", cfg_param, 32'd0);
    check("mid_rst_bypass", {31'd0, cfg_bypass}, 32'd0);
    rd_check(3'd2, 32'h0000_0000, "mid_rst_status");
    rd_check(3'd1, 32'h0, "mid_rst_shadow");

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
